led_serial_tx: RTL
==================

Name: led_serial_tx

Overview:
- Host-side serializer that produces the DAI/DEN bit stream consumed by the LED display controller's serial data input.
- Accepts parallel grayscale words from a source over a valid/ready handshake.
- Shifts each word out MSB-first with DEN high, counts words per frame and signals frame completion.
- Inserts a programmable DEN-low gap between frames.
- Runs entirely in the DCK domain.

Parameters:
- DW, 16, grayscale word width in bits.
- WORDS, 512, words per frame; word counter width is clog2(WORDS).
- FRAME_GAP, 4, DCK cycles with DEN held low after the last bit of a frame; 0 means no gap.

Ports:
- DCK  input  1  data clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din  input  DW  grayscale word from the source.
- din_valid  input  1  din holds a word.
- din_ready  output  1  holding register can take a word.
- DAI  output  1  serial data bit, registered.
- DEN  output  1  serial enable, registered; high exactly when DAI carries a valid bit.
- word_cnt  output  clog2(WORDS)  number of words fully transmitted in the current frame.
- frame_done  output  1  one-cycle pulse after the last bit of word WORDS-1.
- busy  output  1  high in SHIFT or GAP, or while the holding register is full.

Behaviour:
- Reset is asynchronous and active-high: rst clears all state immediately, without waiting for a DCK edge.
  - Reset values: DAI=0, DEN=0, word_cnt=0, frame_done=0, busy=0, holding register empty, state=IDLE.
  - A partially shifted word is discarded.
  - din_ready=1 from the first edge after rst deasserts.
- Handshake:
  - din_ready = !hold_full. This is a registered condition with no combinational path from din_valid.
  - A word is accepted on an edge where din_valid && din_ready; hold_full becomes 1.
  - din is ignored when din_ready=0. The source must hold din stable until the word is accepted.
- Shifter: a DW-bit shift register and a bit counter 0..DW-1.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: DEN=0. On an edge with hold_full=1, the shifter loads from hold, DAI<=hold[DW-1], DEN<=1, bit counter=0, hold_full<=0, go to SHIFT.
  - SHIFT: each edge advances one bit, MSB-first.
    - At the edge ending bit DW-1, word_cnt increments.
    - If word_cnt was WORDS-1: word_cnt wraps to 0, frame_done<=1 for one cycle, DEN<=0, go to GAP (or IDLE if FRAME_GAP=0).
    - Else if hold_full: reload immediately (same rules as IDLE). DEN stays high with no bubble, so back-to-back words are contiguous.
    - Else: DEN<=0, go to IDLE.
  - GAP: DEN=0 for exactly FRAME_GAP cycles, then go to IDLE. A word may be accepted into hold during GAP, but it is not loaded until GAP ends.
- Latency: a word accepted at edge k with the shifter idle drives its MSB on DAI from edge k+1, and its LSB is driven after edge k+DW.
- Throughput: one word per DW cycles when din_valid stays asserted.
- DAI is 0 whenever DEN=0.
- Simultaneous events: if an accept and a hold drain fall on the same edge, hold_full stays 0. This cannot occur because ready=!hold_full, and this is asserted in verification.
- Word counter wrap is modulo WORDS. WORDS need not be a power of two.

Test Plan:
- Reset behaviour: assert rst mid-word (DEN=1, bit 7) -> DEN=0, DAI=0, word_cnt=0 asynchronously, before the next edge. After release, din_ready=1 and the next word starts from its MSB.
- Single word: din=16'hA5C3 accepted at edge k, no further valid -> DAI sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on edges k+1..k+16 with DEN=1. Then DEN=0, word_cnt=1, state IDLE.
- Back-to-back: 3 words 16'hFFFF, 16'h0000, 16'h8001 with din_valid held high -> DEN high for 48 consecutive cycles and DAI matches the concatenated MSB-first bits. din_ready deasserts and reasserts once per word.
- Frame boundary (WORDS=4, FRAME_GAP=3): 6 words streamed continuously -> frame_done pulses one cycle after bit 15 of word 3. word_cnt reads 3 then 0. DEN is low for exactly 3 cycles, then word 4 starts; a word accepted during GAP waits until GAP ends.
- FRAME_GAP=0, WORDS=2: continuous input -> frame_done pulse, and the next frame's MSB follows after exactly one DEN-low cycle (the IDLE load cycle).
- Source stall: din_valid dropped for 5 cycles between words -> DEN=0 during the stall with DAI=0. The next word resumes one edge after acceptance and word_cnt is unchanged across the stall.

Source files
------------

// File: rtl/led_serial_tx.sv
// led_serial_tx
// Host-side serializer that drives the DAI/DEN stream of an LED display
// controller. Parallel grayscale words arrive over a valid/ready handshake
// into a one-word holding register, are shifted out MSB-first with DEN high,
// and are counted per frame. After the last word of a frame DEN is held low
// for FRAME_GAP cycles before the next frame may start.
//
// Ports:
//   DCK        data clock, everything changes on its rising edge
//   rst        asynchronous active-high reset
//   din        grayscale word from the source
//   din_valid  din holds a word
//   din_ready  holding register can take a word (registered)
//   DAI        serial data bit (registered, 0 whenever DEN is 0)
//   DEN        serial enable (registered), high exactly while DAI is valid
//   word_cnt   words fully transmitted in the current frame
//   frame_done one-cycle pulse after the last bit of word WORDS-1
//   busy       shifter/gap active or holding register full (registered)
module led_serial_tx #(
  parameter int DW        = 16,
  parameter int WORDS     = 512,
  parameter int FRAME_GAP = 4,
  localparam int CW       = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          DCK,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          DAI,
  output logic          DEN,
  output logic [CW-1:0] word_cnt,
  output logic          frame_done,
  output logic          busy
);

  localparam int BW       = (DW > 1) ? $clog2(DW) : 1;
  localparam int GW       = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam int GAP_LAST = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   hold, hold_nxt;
  logic            hold_full, hold_full_nxt;
  logic [DW-1:0]   shreg, shreg_nxt;
  logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic [CW-1:0]   word_cnt_nxt;
  logic            dai_nxt, den_nxt, frame_done_nxt;
  logic            busy_nxt, din_ready_nxt;
  logic            accept, load;

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    bit_cnt_nxt    = bit_cnt;
    gap_cnt_nxt    = gap_cnt;
    word_cnt_nxt   = word_cnt;
    dai_nxt        = 1'b0;
    den_nxt        = 1'b0;
    frame_done_nxt = 1'b0;
    load           = 1'b0;
    accept         = din_valid && din_ready;

    case (state)
      IDLE: begin
        if (hold_full) begin
          load = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt == BW'(DW - 1)) begin
          if (word_cnt == CW'(WORDS - 1)) begin
            word_cnt_nxt   = '0;
            frame_done_nxt = 1'b1;
            gap_cnt_nxt    = '0;
            state_nxt      = (FRAME_GAP == 0) ? IDLE : GAP;
          end else begin
            word_cnt_nxt = word_cnt + CW'(1);
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end else begin
          shreg_nxt   = {shreg[DW-2:0], 1'b0};
          dai_nxt     = shreg[DW-2];
          den_nxt     = 1'b1;
          bit_cnt_nxt = bit_cnt + BW'(1);
        end
      end
      GAP: begin
        // The final gap cycle doubles as the load cycle, so DEN is low for
        // exactly FRAME_GAP cycles; a word waiting in hold starts right after.
        if (gap_cnt == GW'(GAP_LAST)) begin
          if (hold_full) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (load) begin
      shreg_nxt   = hold;
      dai_nxt     = hold[DW-1];
      den_nxt     = 1'b1;
      bit_cnt_nxt = '0;
      state_nxt   = SHIFT;
    end else begin
      shreg_nxt   = shreg_nxt;
    end

    // A drain wins over an accept; ready=!hold_full keeps them exclusive.
    if (load) begin
      hold_full_nxt = 1'b0;
    end else if (accept) begin
      hold_full_nxt = 1'b1;
    end else begin
      hold_full_nxt = hold_full;
    end

    if (accept) begin
      hold_nxt = din;
    end else begin
      hold_nxt = hold;
    end

    din_ready_nxt = !hold_full_nxt;
    busy_nxt      = (state_nxt != IDLE) || hold_full_nxt;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge DCK or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      word_cnt   <= '0;
      DAI        <= 1'b0;
      DEN        <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      din_ready  <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      hold_full  <= hold_full_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      word_cnt   <= word_cnt_nxt;
      DAI        <= dai_nxt;
      DEN        <= den_nxt;
      frame_done <= frame_done_nxt;
      busy       <= busy_nxt;
      din_ready  <= din_ready_nxt;
    end
  end

endmodule
